// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART receive constants: FSM encodings, FIFO sizing and bit timing defaults.
// Also used by the 6809-facing uart_interface so both sides agree on sizes.
package uart_rx_fifo_pkg;

    // 44.33 MHz oscillator / 115200 baud
    localparam int unsigned CLKS_PER_BIT_DEF = 385;
    localparam int unsigned FIFO_DEPTH_DEF   = 16;
    localparam int unsigned CNT_W_DEF        = 5;
    localparam int unsigned DATA_W           = 8;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

    // Outcome of one stop-bit sample: a byte to push or a framing error
    typedef struct packed {
        logic              push;
        logic              framing;
        logic [DATA_W-1:0] data;
    } rx_evt_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with a separately kept occupancy count.
// Head byte, valid, full and count are all registered; an empty FIFO presents zero data.
module sync_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W,
    parameter int unsigned DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             not_empty,
    output logic             full,
    output logic [CNT_W-1:0] count,
    output logic             drop_c
);

    localparam int unsigned AW = CNT_W - 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             valid_q, valid_d;
    logic             full_q, full_d;
    logic             push_ok_c, pop_ok_c;

    // A push into a full FIFO still lands when a pop frees a slot in the same cycle
    always_comb begin
        pop_ok_c  = pop && (count_q != '0);
        push_ok_c = push && ((count_q != CNT_W'(DEPTH)) || pop_ok_c);
        drop_c    = push && !push_ok_c;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_c) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok_c) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_ok_c && !pop_ok_c) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_ok_c && !push_ok_c) begin
            count_d = count_q - CNT_W'(1);
        end

        valid_d = (count_d != '0);
        full_d  = (count_d == CNT_W'(DEPTH));

        // The byte written this cycle is the new head only when it is the sole entry
        head_d = '0;
        if (count_d != '0) begin
            if (push_ok_c && (rd_ptr_d == wr_ptr_q)) begin
                head_d = wr_data;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
        end
    end

    assign rd_data   = head_q;
    assign not_empty = valid_q;
    assign full      = full_q;
    assign count     = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a show-ahead receive FIFO for the 6809 register block.
// Holds the serial FSM, the line synchronizer and the sticky overrun/framing flags.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_UART_TX,
    input  logic              i_rd_strobe,
    input  logic              i_clear_err,
    input  logic              i_irq_en,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_rx_valid,
    output logic              o_rx_full,
    output logic [CNT_W-1:0]  o_rx_count,
    output logic              o_overrun,
    output logic              o_framing_err,
    output logic              o_irq_req
);

    localparam int unsigned    BIT_CW  = $clog2(CLKS_PER_BIT);
    localparam logic [BIT_CW-1:0] HALF_M1 = BIT_CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_CW-1:0] FULL_M1 = BIT_CW'(CLKS_PER_BIT - 1);

    logic              rx_meta_q, rx_s_q;
    logic [2:0]        state_q, state_d;
    logic [BIT_CW-1:0] cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              overrun_q, overrun_d;
    logic              framing_q, framing_d;
    rx_evt_t           evt_c;
    logic              fifo_drop_c;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start bit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= i_UART_TX;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q + BIT_CW'(1);
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        evt_c         = '0;
        evt_c.data    = shift_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s_q ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s_q, shift_q[DATA_W-1:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        evt_c.push = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        evt_c.framing = 1'b1;
                        state_d       = ST_WAIT_HIGH;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                // A held-low break must not look like a stream of new start bits
                cnt_d = '0;
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        overrun_d = (overrun_q & ~i_clear_err) | fifo_drop_c;
        framing_d = (framing_q & ~i_clear_err) | evt_c.framing;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            overrun_q <= 1'b0;
            framing_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            overrun_q <= overrun_d;
            framing_q <= framing_d;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (evt_c.push),
        .wr_data   (evt_c.data),
        .pop       (i_rd_strobe),
        .rd_data   (o_rx_data),
        .not_empty (o_rx_valid),
        .full      (o_rx_full),
        .count     (o_rx_count),
        .drop_c    (fifo_drop_c)
    );

    assign o_overrun     = overrun_q;
    assign o_framing_err = framing_q;
    assign o_irq_req     = o_rx_valid & i_irq_en;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed frames plus random traffic
// compared against a queue-based model of the receive FIFO and error flags.
module tb_uart_rx_fifo;

    localparam int unsigned CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       line;
    logic       rd;
    logic       clr;
    logic       irq_en;
    logic [7:0] o_rx_data;
    logic       o_rx_valid;
    logic       o_rx_full;
    logic [4:0] o_rx_count;
    logic       o_overrun;
    logic       o_framing_err;
    logic       o_irq_req;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (16),
        .CNT_W        (5)
    ) dut (
        .clk           (clk),
        .reset         (rst_n),
        .i_UART_TX     (line),
        .i_rd_strobe   (rd),
        .i_clear_err   (clr),
        .i_irq_en      (irq_en),
        .o_rx_data     (o_rx_data),
        .o_rx_valid    (o_rx_valid),
        .o_rx_full     (o_rx_full),
        .o_rx_count    (o_rx_count),
        .o_overrun     (o_overrun),
        .o_framing_err (o_framing_err),
        .o_irq_req     (o_irq_req)
    );

    logic [7:0] q[$];
    bit         m_ovr;
    bit         m_fe;
    int         total = 0;
    int         bad   = 0;
    int         fv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        logic [7:0] exp_data;
        bit         exp_valid;
        exp_data  = (q.size() > 0) ? q[0] : 8'h00;
        exp_valid = (q.size() > 0);
        chk({tag, ":data"},  32'(o_rx_data),     32'(exp_data));
        chk({tag, ":valid"}, 32'(o_rx_valid),    32'(exp_valid));
        chk({tag, ":full"},  32'(o_rx_full),     32'(q.size() == 16));
        chk({tag, ":count"}, 32'(o_rx_count),    32'(q.size()));
        chk({tag, ":ovr"},   32'(o_overrun),     32'(m_ovr));
        chk({tag, ":fe"},    32'(o_framing_err), 32'(m_fe));
        chk({tag, ":irq"},   32'(o_irq_req),     32'(exp_valid & irq_en));
    endtask

    // Model of one received frame; a same-cycle pop is applied before the push
    task automatic m_frame(input logic [7:0] d, input bit stop, input bit popped);
        if (popped && q.size() > 0) void'(q.pop_front());
        if (!stop) m_fe = 1'b1;
        else if (q.size() < 16) q.push_back(d);
        else m_ovr = 1'b1;
    endtask

    // Drives one 10-bit frame starting at a falling clock edge; optional pop at cycle pop_at
    task automatic send_frame(input logic [7:0] d, input bit stop, input int pop_at,
                              output int first_valid);
        first_valid = -1;
        for (int c = 0; c < 10 * CPB; c++) begin
            int b;
            b = c / CPB;
            if (b == 0) line = 1'b0;
            else if (b <= 8) line = d[b-1];
            else line = stop;
            rd = (c == pop_at);
            @(negedge clk);
            if (first_valid < 0 && o_rx_valid) first_valid = c + 1;
        end
        rd = 1'b0;
    endtask

    task automatic pop_one();
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
    endtask

    task automatic clear_err();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        m_ovr = 1'b0;
        m_fe  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        repeat (200000) @(posedge clk);
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rb;
        bit         rs;
        line = 1'b1; rd = 1'b0; clr = 1'b0; irq_en = 1'b1; rst_n = 1'b0;
        m_ovr = 1'b0; m_fe = 1'b0;
        idle(3);
        chk_all("reset");
        rst_n = 1'b1;
        idle(5);

        // Single frame: valid rises exactly one edge after the stop sample
        send_frame(8'hA5, 1'b1, -1, fv);
        m_frame(8'hA5, 1'b1, 1'b0);
        chk("latency", 32'(fv), 32'd155);
        chk_all("a5");
        irq_en = 1'b0;
        idle(1);
        chk_all("a5_irq_off");
        irq_en = 1'b1;
        pop_one();
        chk_all("a5_pop");

        // 17 frames without pops: fill, then overrun
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 1'b1, -1, fv);
            m_frame(8'(i), 1'b1, 1'b0);
            if (i == 15) chk_all("full16");
        end
        chk_all("ovr17");
        for (int i = 0; i < 16; i++) begin
            chk("order", 32'(o_rx_data), 32'(i));
            pop_one();
            chk_all("drain");
        end
        pop_one();
        chk_all("pop_empty");
        clear_err();
        chk_all("clr_ovr");

        // Framing error followed by a long break
        send_frame(8'h3C, 1'b0, -1, fv);
        m_frame(8'h3C, 1'b0, 1'b0);
        idle(40 * CPB);
        chk_all("fe_break");
        line = 1'b1;
        idle(3 * CPB);
        chk_all("fe_release");
        clear_err();
        chk_all("fe_clr");

        // Short low glitch is rejected
        line = 1'b0;
        idle(4);
        line = 1'b1;
        idle(2 * CPB);
        chk_all("glitch");
        send_frame(8'hC3, 1'b1, -1, fv);
        m_frame(8'hC3, 1'b1, 1'b0);
        chk_all("post_glitch");
        pop_one();

        // Pop in the same cycle as a push into a full FIFO
        for (int i = 0; i < 16; i++) begin
            rb = 8'($urandom);
            send_frame(rb, 1'b1, -1, fv);
            m_frame(rb, 1'b1, 1'b0);
        end
        chk_all("refill");
        send_frame(8'h77, 1'b1, 154, fv);
        m_frame(8'h77, 1'b1, 1'b1);
        chk_all("same_cycle");
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("last77", 32'(o_rx_data), 32'h77);
            pop_one();
            chk_all("same_drain");
        end

        // Random traffic against the model
        for (int it = 0; it < 40; it++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(7) != 0);
            irq_en = 1'($urandom);
            send_frame(rb, rs, -1, fv);
            m_frame(rb, rs, 1'b0);
            line = 1'b1;
            idle(2 + int'($urandom_range(20)));
            chk_all("rnd_rx");
            for (int k = 0; k < int'($urandom_range(2)); k++) begin
                pop_one();
                chk_all("rnd_pop");
            end
            if ($urandom_range(9) == 0) begin
                clear_err();
                chk_all("rnd_clr");
            end
        end

        // Reset in the middle of a data bit
        irq_en = 1'b1;
        while (q.size() > 0) pop_one();
        clear_err();
        for (int i = 0; i < 3; i++) begin
            rb = 8'($urandom);
            send_frame(rb, 1'b1, -1, fv);
            m_frame(rb, 1'b1, 1'b0);
        end
        chk_all("pre_reset");
        line = 1'b0;
        idle(CPB);
        for (int i = 0; i < 3 * CPB; i++) begin
            line = 1'((i / CPB) & 1);
            idle(1);
        end
        rst_n = 1'b0;
        #1;
        q.delete();
        m_ovr = 1'b0;
        m_fe  = 1'b0;
        chk_all("async_reset");
        line = 1'b1;
        @(negedge clk);
        idle(3);
        chk_all("in_reset");
        rst_n = 1'b1;
        idle(20);
        chk_all("post_reset");
        send_frame(8'h5A, 1'b1, -1, fv);
        m_frame(8'h5A, 1'b1, 1'b0);
        chk_all("rx_5a");
        pop_one();
        chk_all("rx_5a_pop");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
